// File: rtl/idfwd_pkg.sv
// Shared types and helpers for the ID-stage forwarding scoreboard.
// Pipe entries carry a fixed-width rd field; designs use the low REG_AW bits.
package idfwd_pkg;

    localparam int SEL_REGFILE = 0;
    localparam int RD_MAX_W    = 8;

    typedef struct packed {
        logic                vld;
        logic                wr;
        logic                ld;
        logic [RD_MAX_W-1:0] rd;
    } entry_t;

    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/idfwd_match.sv
// Per-operand youngest-first priority encoder over the in-flight destination pipe.
// Honours IDFWD_ZERO_REG_EN: when defined, a source of register 0 never matches.
module idfwd_match
    import idfwd_pkg::*;
#(
    parameter int REG_AW = 2,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = 2
) (
    input  entry_t [DEPTH:1]  entries,
    input  logic [REG_AW-1:0] rs,
    output logic [SEL_W-1:0]  sel,
    output logic              is_load_hit
);

    logic [RD_MAX_W-1:0] rs_ext_s;
    logic                rs_live_s;

    // Zero-extend the source register to the entry rd width.
    always_comb begin
        rs_ext_s             = '0;
        rs_ext_s[REG_AW-1:0] = rs;
    end

`ifdef IDFWD_ZERO_REG_EN
    assign rs_live_s = (rs != '0);
`else
    assign rs_live_s = 1'b1;
`endif

    // Oldest-to-youngest scan so the youngest matching stage overrides the rest.
    always_comb begin
        logic hit_s;
        sel         = SEL_W'(SEL_REGFILE);
        is_load_hit = 1'b0;
        hit_s       = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            hit_s       = rs_live_s & entries[k].vld & entries[k].wr
                        & (entries[k].rd == rs_ext_s);
            sel         = hit_s ? SEL_W'(k) : sel;
            is_load_hit = hit_s ? entries[k].ld : is_load_hit;
        end
    end

endmodule

// File: rtl/id_forward_scoreboard.sv
// ID-stage forwarding select and load-use stall generation with a saturating stall counter.
// Optional macro IDFWD_ZERO_REG_EN makes register 0 a hardwired zero.
module id_forward_scoreboard
    import idfwd_pkg::*;
#(
    parameter int REG_AW     = 2,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = sel_w(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic                      id_regwrite,
    input  logic                      id_is_load,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic                      flush,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam logic [SEL_W-1:0] LOAD_SEL = SEL_W'(LOAD_STAGE);

    entry_t [DEPTH:1]              pipe_r;
    entry_t                        new_entry_s;
    logic [NUM_SRC-1:0][SEL_W-1:0] sel_s;
    logic [NUM_SRC-1:0]            load_hit_s;
    logic [NUM_SRC-1:0]            hz_s;
    logic                          stall_s;
    logic                          id_wr_s;
    logic [CNT_W-1:0]              stall_cnt_r;

    generate
        for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
            idfwd_match #(
                .REG_AW (REG_AW),
                .DEPTH  (DEPTH),
                .SEL_W  (SEL_W)
            ) u_match (
                .entries     (pipe_r),
                .rs          (id_rs[s*REG_AW +: REG_AW]),
                .sel         (sel_s[s]),
                .is_load_hit (load_hit_s[s])
            );

            // A load hit is only a hazard while it sits before the forwardable stage.
            assign hz_s[s] = id_valid & load_hit_s[s] & (sel_s[s] < LOAD_SEL);
            assign fwd_sel[s*SEL_W +: SEL_W] = sel_s[s];
        end
    endgenerate

    assign stall_s = (|hz_s) & ~flush;

`ifdef IDFWD_ZERO_REG_EN
    assign id_wr_s = id_regwrite & (id_rd != '0);
`else
    assign id_wr_s = id_regwrite;
`endif

    // Entry-1 candidate: stalled or flushed issues enter as bubbles.
    always_comb begin
        new_entry_s                = '0;
        new_entry_s.vld            = id_valid & ~stall_s & ~flush;
        new_entry_s.wr             = id_wr_s;
        new_entry_s.ld             = id_is_load;
        new_entry_s.rd[REG_AW-1:0] = id_rd;
    end

    // Shift pipe: older entries always advance, even during a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_r <= '0;
        end else begin
            pipe_r[1] <= new_entry_s;
            for (int k = 2; k <= DEPTH; k++) begin
                pipe_r[k] <= pipe_r[k-1];
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= '0;
        end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall     = stall_s;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_id_forward_scoreboard.sv
// Scoreboard bench: directed scenarios plus random traffic against an issue-history model.
module tb_id_forward_scoreboard;

    localparam int REG_AW     = 2;
    localparam int NUM_SRC    = 2;
    localparam int DEPTH      = 3;
    localparam int LOAD_STAGE = 2;
    localparam int CNT_W      = 16;
    localparam int SEL_W      = 2;
    localparam int MAXC       = 4096;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      id_valid;
    logic                      id_regwrite;
    logic                      id_is_load;
    logic [REG_AW-1:0]         id_rd;
    logic [NUM_SRC*REG_AW-1:0] id_rs;
    logic                      flush;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
    logic                      stall;
    logic [CNT_W-1:0]          stall_cnt;

    always #5 clk = ~clk;

    id_forward_scoreboard #(
        .REG_AW     (REG_AW),
        .NUM_SRC    (NUM_SRC),
        .DEPTH      (DEPTH),
        .LOAD_STAGE (LOAD_STAGE),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_regwrite (id_regwrite),
        .id_is_load  (id_is_load),
        .id_rd       (id_rd),
        .id_rs       (id_rs),
        .flush       (flush),
        .fwd_sel     (fwd_sel),
        .stall       (stall),
        .stall_cnt   (stall_cnt)
    );

    typedef struct packed {
        logic [NUM_SRC*SEL_W-1:0] sel;
        logic                     stall;
        logic [CNT_W-1:0]         cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Issue history indexed by cycle number; stage k in cycle c holds the issue of cycle c-k.
    bit       m_vld [MAXC];
    bit       m_wr  [MAXC];
    bit       m_ld  [MAXC];
    bit [1:0] m_rd  [MAXC];
    int       cyc        = 0;
    int       last_reset = -1;
    int       m_cnt      = 0;
    bit       m_stall    = 1'b0;

    function automatic bit zero_mode();
`ifdef IDFWD_ZERO_REG_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        else n_pass++;
    endtask

    // Record what the clock edge does with the inputs of the cycle just ending.
    task automatic commit();
        if (reset) begin
            last_reset = cyc;
            m_cnt      = 0;
        end else begin
            m_vld[cyc] = id_valid && !m_stall && !flush;
            m_wr[cyc]  = id_regwrite && !(zero_mode() && id_rd == 2'd0);
            m_ld[cyc]  = id_is_load;
            m_rd[cyc]  = id_rd;
            if (m_stall && m_cnt < 65535) m_cnt++;
        end
        cyc++;
    endtask

    function automatic exp_t predict();
        exp_t e;
        bit   any_hz;
        any_hz = 1'b0;
        e      = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            bit [1:0] rs;
            int       age;
            rs  = id_rs[s*REG_AW +: REG_AW];
            age = 0;
            for (int k = 1; k <= DEPTH; k++) begin
                int c;
                c = cyc - k;
                if (age == 0 && c > last_reset && c >= 0 && m_vld[c] && m_wr[c]
                    && m_rd[c] == rs && !(zero_mode() && rs == 2'd0))
                    age = k;
            end
            e.sel[s*SEL_W +: SEL_W] = 2'(age);
            if (age != 0 && m_ld[cyc-age] && age < LOAD_STAGE && id_valid && !flush)
                any_hz = 1'b1;
        end
        e.stall = any_hz;
        e.cnt   = 16'(m_cnt);
        return e;
    endfunction

    task automatic step(input bit rst, input bit v, input bit rw, input bit ld,
                        input bit [1:0] rd, input bit [1:0] r0, input bit [1:0] r1,
                        input bit fl);
        exp_t e;
        @(posedge clk);
        commit();
        #1;
        reset       = rst;
        id_valid    = v;
        id_regwrite = rw;
        id_is_load  = ld;
        id_rd       = rd;
        id_rs       = {r1, r0};
        flush       = fl;
        e           = predict();
        m_stall     = e.stall;
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: compares the DUT against the queued expectation once per cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_fwd_sel", 32'(fwd_sel), 32'(e.sel));
                check("mon_stall", 32'(stall), 32'(e.stall));
                check("mon_stall_cnt", 32'(stall_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit       r_rst, r_v, r_rw, r_ld, r_fl;
        bit [1:0] r_rd, r_r0, r_r1;

        reset = 1'b1; id_valid = 1'b0; id_regwrite = 1'b0; id_is_load = 1'b0;
        id_rd = '0; id_rs = '0; flush = 1'b0;

        // Fresh after reset: nothing forwards or stalls.
        step(0, 1, 0, 0, 2'd0, 2'd2, 2'd3, 0);
        check("reset_fwd_sel", 32'(fwd_sel), 32'h0);
        check("reset_stall", 32'(stall), 32'h0);
        check("reset_cnt", 32'(stall_cnt), 32'h0);

        // ALU producer r1 seen at stage 1 then stage 2.
        step(0, 1, 1, 0, 2'd1, 2'd0, 2'd0, 0);
        step(0, 1, 0, 0, 2'd0, 2'd1, 2'd0, 0);
        check("alu_stage1", 32'(fwd_sel[1:0]), 32'd1);
        step(0, 1, 0, 0, 2'd0, 2'd1, 2'd0, 0);
        check("alu_stage2", 32'(fwd_sel[1:0]), 32'd2);

        // r2 in stages 1 and 3: youngest wins.
        step(0, 1, 1, 0, 2'd2, 2'd0, 2'd0, 0);
        step(0, 1, 0, 0, 2'd2, 2'd0, 2'd0, 0);
        step(0, 1, 1, 0, 2'd2, 2'd0, 2'd0, 0);
        step(0, 1, 0, 0, 2'd0, 2'd0, 2'd2, 0);
        check("youngest_wins", 32'(fwd_sel[3:2]), 32'd1);

        // Load-use: one stall, then forward from stage 2.
        step(0, 1, 1, 1, 2'd3, 2'd0, 2'd0, 0);
        step(0, 1, 0, 0, 2'd0, 2'd3, 2'd0, 0);
        check("load_use_stall", 32'(stall), 32'd1);
        check("load_use_cnt0", 32'(stall_cnt), 32'd0);
        step(0, 1, 0, 0, 2'd0, 2'd3, 2'd0, 0);
        check("load_use_release", 32'(stall), 32'd0);
        check("load_use_fwd", 32'(fwd_sel[1:0]), 32'd2);
        check("load_use_cnt1", 32'(stall_cnt), 32'd1);

        // Load-use hazard masked by flush; the flushed writer of r1 becomes a bubble.
        step(0, 1, 1, 1, 2'd3, 2'd0, 2'd0, 0);
        step(0, 1, 1, 0, 2'd1, 2'd3, 2'd0, 1);
        check("flush_stall", 32'(stall), 32'd0);
        step(0, 1, 0, 0, 2'd0, 2'd3, 2'd1, 0);
        check("flush_bubble", 32'(fwd_sel), 32'h2);
        check("flush_cnt", 32'(stall_cnt), 32'd1);

        // Both operands forward from the same stage-2 producer.
        step(0, 1, 1, 0, 2'd1, 2'd0, 2'd0, 0);
        step(0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 0);
        step(0, 1, 0, 0, 2'd0, 2'd1, 2'd1, 0);
        check("dual_fwd", 32'(fwd_sel), 32'ha);

        // Register 0 producer (load): ordinary register or hardwired zero.
        step(0, 1, 1, 1, 2'd0, 2'd3, 2'd3, 0);
        step(0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 0);
        if (zero_mode()) begin
            check("r0_zero_fwd", 32'(fwd_sel), 32'h0);
            check("r0_zero_stall", 32'(stall), 32'd0);
        end else begin
            check("r0_fwd", 32'(fwd_sel), 32'h5);
            check("r0_stall", 32'(stall), 32'd1);
        end

        // Reset discards in-flight producers and clears the counter.
        step(1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 0);
        step(0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 0);
        check("post_reset_fwd", 32'(fwd_sel), 32'h0);
        check("post_reset_stall", 32'(stall), 32'd0);
        check("post_reset_cnt", 32'(stall_cnt), 32'd0);

        // Random traffic; stalled instructions are usually held like a real front end.
        r_rst = 0; r_v = 0; r_rw = 0; r_ld = 0; r_fl = 0; r_rd = 0; r_r0 = 0; r_r1 = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!(m_stall && $urandom_range(0, 9) < 7)) begin
                r_v  = ($urandom_range(0, 99) < 85);
                r_rw = ($urandom_range(0, 99) < 70);
                r_ld = ($urandom_range(0, 99) < 35);
                r_rd = 2'($urandom_range(0, 3));
                r_r0 = 2'($urandom_range(0, 3));
                r_r1 = 2'($urandom_range(0, 3));
            end
            r_fl  = ($urandom_range(0, 99) < 8);
            r_rst = ($urandom_range(0, 99) < 2);
            step(r_rst, r_v, r_rw, r_ld, r_rd, r_r0, r_r1, r_fl);
        end

        repeat (3) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
